// File: rtl/msdf_otf_converter.sv
// Converts a radix-2 MSDF signed-digit stream into a left-aligned two's-complement word using Q/QM on-the-fly conversion.
// Latency: the edge that samples the wlast digit moves to ALIGN, and o_res_valid is high after the following edge.
// Backpressure: o_mbus_wstop stays high from the last digit until the consumer takes the result with i_res_ready.
module msdf_otf_converter #(
  parameter int unsigned ACCURATE_MAX = 64,
  parameter int unsigned CNT_WIDTH    = $clog2(ACCURATE_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_mbus_wen,
  input  logic [1:0]              i_mbus_wdata,
  input  logic                    i_mbus_wpoint,
  input  logic                    i_mbus_wvalid,
  input  logic                    i_mbus_wlast,
  output logic                    o_mbus_wstop,
  output logic                    o_mbus_wclr,
  input  logic                    i_clr,
  output logic [ACCURATE_MAX:0]   o_res_data,
  output logic [CNT_WIDTH-1:0]    o_res_point,
  output logic [CNT_WIDTH-1:0]    o_res_ndig,
  output logic                    o_res_trunc,
  output logic                    o_res_valid,
  input  logic                    i_res_ready
);

  localparam int unsigned          W       = ACCURATE_MAX + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(ACCURATE_MAX);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    ALIGN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic signed [W-1:0]   q;
  logic signed [W-1:0]   qm;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  point_reg;
  logic [CNT_WIDTH-1:0]  shamt;
  logic                  point_seen;
  logic                  trunc_flag;
  logic                  accept;
  logic                  room;
  logic                  d_pos;
  logic                  d_neg;

  // Only {1,0} and {0,1} carry weight; both other codes mean zero.
  assign d_pos  = (i_mbus_wdata == 2'b10);
  assign d_neg  = (i_mbus_wdata == 2'b01);
  assign accept = (state == ACC) && i_mbus_wen && i_mbus_wvalid;
  assign room   = (cnt < CNT_MAX);
  // Left-align: a short operand is padded with zero digits below its last digit.
  assign shamt  = CNT_MAX - cnt;

  assign o_mbus_wstop = (state != ACC);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a consumer clear always returns to accepting digits.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && i_mbus_wlast) state_nxt = ALIGN;
      ALIGN:   state_nxt = HOLD;
      HOLD:    if (i_res_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (i_clr) state_nxt = ACC;
  end

  // Clear request echoed upstream one cycle later.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mbus_wclr <= 1'b0;
    end else begin
      o_mbus_wclr <= i_clr;
    end
  end

  // On-the-fly conversion registers, point/truncation tracking and result outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      q           <= '0;
      qm          <= '1;
      cnt         <= '0;
      point_reg   <= '0;
      point_seen  <= 1'b0;
      trunc_flag  <= 1'b0;
      o_res_data  <= '0;
      o_res_point <= '0;
      o_res_ndig  <= '0;
      o_res_trunc <= 1'b0;
      o_res_valid <= 1'b0;
    end else if (i_clr) begin
      q           <= '0;
      qm          <= '1;
      cnt         <= '0;
      point_reg   <= '0;
      point_seen  <= 1'b0;
      trunc_flag  <= 1'b0;
      o_res_data  <= '0;
      o_res_point <= '0;
      o_res_ndig  <= '0;
      o_res_trunc <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (room) begin
          // Q holds the value so far, QM holds Q minus one ulp.
          if (d_pos) begin
            q  <= {q[W-2:0], 1'b1};
            qm <= {q[W-2:0], 1'b0};
          end else if (d_neg) begin
            q  <= {qm[W-2:0], 1'b1};
            qm <= {qm[W-2:0], 1'b0};
          end else begin
            q  <= {q[W-2:0], 1'b0};
            qm <= {qm[W-2:0], 1'b1};
          end
          cnt <= cnt + CNT_WIDTH'(1);
        end else begin
          // Digits beyond the fraction width are dropped but remembered.
          trunc_flag <= 1'b1;
        end
        if (i_mbus_wpoint && !point_seen) begin
          point_reg  <= cnt;
          point_seen <= 1'b1;
        end
      end

      if (state == ALIGN) begin
        o_res_data  <= q << shamt;
        o_res_ndig  <= cnt;
        o_res_point <= point_seen ? point_reg : cnt;
        o_res_trunc <= trunc_flag;
        o_res_valid <= 1'b1;
      end

      if ((state == HOLD) && i_res_ready) begin
        o_res_valid <= 1'b0;
        q           <= '0;
        qm          <= '1;
        cnt         <= '0;
        point_reg   <= '0;
        point_seen  <= 1'b0;
        trunc_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Randomized and directed bench for msdf_otf_converter with an arithmetic reference model.
// Expected results come from summing digit weights; stage tracking gives the expected handshake timing.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_msdf_otf_converter;

  localparam int AM = 8;
  localparam int CW = 4;

  logic          clk;
  logic          i_rstn;
  logic          i_mbus_wen;
  logic [1:0]    i_mbus_wdata;
  logic          i_mbus_wpoint;
  logic          i_mbus_wvalid;
  logic          i_mbus_wlast;
  logic          o_mbus_wstop;
  logic          o_mbus_wclr;
  logic          i_clr;
  logic [AM:0]   o_res_data;
  logic [CW-1:0] o_res_point;
  logic [CW-1:0] o_res_ndig;
  logic          o_res_trunc;
  logic          o_res_valid;
  logic          i_res_ready;

  msdf_otf_converter #(.ACCURATE_MAX(AM)) dut (
    .i_clk         (clk),
    .i_rstn        (i_rstn),
    .i_mbus_wen    (i_mbus_wen),
    .i_mbus_wdata  (i_mbus_wdata),
    .i_mbus_wpoint (i_mbus_wpoint),
    .i_mbus_wvalid (i_mbus_wvalid),
    .i_mbus_wlast  (i_mbus_wlast),
    .o_mbus_wstop  (o_mbus_wstop),
    .o_mbus_wclr   (o_mbus_wclr),
    .i_clr         (i_clr),
    .o_res_data    (o_res_data),
    .o_res_point   (o_res_point),
    .o_res_ndig    (o_res_ndig),
    .o_res_trunc   (o_res_trunc),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ready_pct = 100;
  int bubble_pct = 0;
  int op_d[0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_digs[$];
  int         m_pidx;
  int         m_stage;     // 0 accepting, 1 last digit just taken, 2 result on offer
  logic       m_wclr;
  logic [AM:0] m_data;
  int         m_point;
  int         m_ndig;
  logic       m_trunc;

  function automatic int dig_of(input logic [1:0] code);
    if (code == 2'b10) return 1;
    if (code == 2'b01) return -1;
    return 0;
  endfunction

  // Result scaled by 2^AM: digit i (0-based) weighs 2^(AM-1-i).
  function automatic int model_value();
    int v = 0;
    int n = m_digs.size();
    int lim = (n < AM) ? n : AM;
    for (int i = 0; i < lim; i++) v += m_digs[i] * (1 << (AM - 1 - i));
    return v;
  endfunction

  task automatic model_clear();
    m_digs.delete();
    m_pidx  = -1;
    m_stage = 0;
  endtask

  initial begin
    model_clear();
    m_wclr  = 1'b0;
    m_data  = '0;
    m_point = 0;
    m_ndig  = 0;
    m_trunc = 1'b0;
  end

  // Compare process: check outputs against the model, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    int v;
    int n;
    if (!i_rstn) begin
      chk("rst_valid", {31'd0, o_res_valid}, 32'd0);
      chk("rst_wstop", {31'd0, o_mbus_wstop}, 32'd0);
      chk("rst_wclr",  {31'd0, o_mbus_wclr}, 32'd0);
      chk("rst_data",  32'(o_res_data), 32'd0);
      chk("rst_point", 32'(o_res_point), 32'd0);
      model_clear();
      m_wclr = 1'b0;
    end else begin
      chk("wstop", {31'd0, o_mbus_wstop}, {31'd0, (m_stage != 0)});
      chk("wclr",  {31'd0, o_mbus_wclr},  {31'd0, m_wclr});
      chk("valid", {31'd0, o_res_valid},  {31'd0, (m_stage == 2)});
      if (m_stage == 2) begin
        chk("data",  32'(o_res_data),  32'(m_data));
        chk("point", 32'(o_res_point), 32'(m_point));
        chk("ndig",  32'(o_res_ndig),  32'(m_ndig));
        chk("trunc", {31'd0, o_res_trunc}, {31'd0, m_trunc});
      end
      m_wclr = i_clr;
      if (i_clr) begin
        model_clear();
      end else if (m_stage == 0) begin
        if (i_mbus_wen && i_mbus_wvalid) begin
          if (i_mbus_wpoint && m_pidx < 0) m_pidx = m_digs.size();
          m_digs.push_back(dig_of(i_mbus_wdata));
          if (i_mbus_wlast) begin
            n       = m_digs.size();
            v       = model_value();
            m_data  = v[AM:0];
            m_ndig  = (n < AM) ? n : AM;
            m_trunc = (n > AM);
            m_point = (m_pidx >= 0) ? ((m_pidx < AM) ? m_pidx : AM) : m_ndig;
            m_stage = 1;
          end
        end
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (i_res_ready) begin
        model_clear();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic wen, input logic wvalid, input logic [1:0] d,
                       input logic pt, input logic last, input logic clr);
    @(posedge clk);
    #1;
    i_mbus_wen    = wen;
    i_mbus_wvalid = wvalid;
    i_mbus_wdata  = d;
    i_mbus_wpoint = pt;
    i_mbus_wlast  = last;
    i_clr         = clr;
    i_res_ready   = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [1:0] enc(input int d);
    if (d > 0) return 2'b10;
    if (d < 0) return 2'b01;
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic send_digit(input int d, input logic pt, input logic last);
    logic [1:0] code;
    int tries;
    int b;
    code  = enc(d);
    tries = 0;
    if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
      b = $urandom_range(0, 2);
      drive(b == 1, b == 0, 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    drive(1'b1, 1'b1, code, pt, last, 1'b0);
    while (o_mbus_wstop && tries < 200) begin
      drive(1'b1, 1'b1, code, pt, last, 1'b0);
      tries++;
    end
    if (tries >= 200) chk("send_timeout", 32'd1, 32'd0);
  endtask

  // Sends op_d[0..n-1]; pidx marks the digit carrying the point (-1 none).
  task automatic send_op(input int n, input int pidx, input logic do_last);
    for (int i = 0; i < n; i++) send_digit(op_d[i], (i == pidx), do_last && (i == n - 1));
  endtask

  task automatic fill(input int v, input int n);
    for (int i = 0; i < n; i++) op_d[i] = v;
  endtask

  // Waits (bounded) for a result and checks it against hand-computed literals; the model result is pinned too.
  task automatic check_lit(input string nm, input logic [AM:0] ed, input int endig,
                           input logic etr, input int ept);
    int k;
    logic found;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      drive_idle();
      @(negedge clk);
      #1;
      if (o_res_valid) found = 1'b1;
      k++;
    end
    chk({nm, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({nm, "_data"},  32'(o_res_data),  32'(ed));
      chk({nm, "_ndig"},  32'(o_res_ndig),  32'(endig));
      chk({nm, "_trunc"}, {31'd0, o_res_trunc}, {31'd0, etr});
      chk({nm, "_point"}, 32'(o_res_point), 32'(ept));
      chk({nm, "_model"}, 32'(m_data), 32'(ed));
    end
  endtask

  initial begin
    int n;
    int pidx;
    i_rstn = 1'b1;
    i_mbus_wen = 1'b0; i_mbus_wvalid = 1'b0; i_mbus_wdata = 2'b00;
    i_mbus_wpoint = 1'b0; i_mbus_wlast = 1'b0; i_clr = 1'b0; i_res_ready = 1'b0;
    #1 i_rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rstn = 1'b1;

    // Basic conversions.
    op_d[0] = 1; op_d[1] = 0; op_d[2] = -1;
    send_op(3, -1, 1'b1);
    check_lit("p0m", 9'h060, 3, 1'b0, 3);
    op_d[0] = -1; op_d[1] = 1;
    send_op(2, -1, 1'b1);
    check_lit("mp", 9'h1C0, 2, 1'b0, 2);
    fill(1, 8);
    send_op(8, -1, 1'b1);
    check_lit("p8", 9'h0FF, 8, 1'b0, 8);
    fill(-1, 8);
    send_op(8, -1, 1'b1);
    check_lit("m8", 9'h101, 8, 1'b0, 8);
    fill(1, 10);
    send_op(10, -1, 1'b1);
    check_lit("p10", 9'h0FF, 8, 1'b1, 8);

    // Point marker capture.
    op_d[0] = 1; op_d[1] = 0; op_d[2] = 0; op_d[3] = 1;
    send_op(4, 2, 1'b1);
    check_lit("pt2", 9'h090, 4, 1'b0, 2);
    op_d[0] = 1; op_d[1] = 1; op_d[2] = -1; op_d[3] = 0;
    send_op(4, -1, 1'b1);
    check_lit("pt4", 9'h0A0, 4, 1'b0, 4);

    // Stalled consumer: result stays put and offered digits are not consumed.
    ready_pct = 0;
    fill(1, 2);
    send_op(2, -1, 1'b1);
    check_lit("stall", 9'h0C0, 2, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
      chk("stall_wstop", {31'd0, o_mbus_wstop}, 32'd1);
      chk("stall_data", 32'(o_res_data), 32'h0C0);
    end
    ready_pct = 100;
    op_d[0] = -1;
    send_op(1, -1, 1'b1);
    check_lit("b2b", 9'h180, 1, 1'b0, 1);

    // Consumer clear mid-operand drops it.
    op_d[0] = 1; op_d[1] = -1;
    send_op(2, -1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (4) drive_idle();
    op_d[0] = 1;
    send_op(1, -1, 1'b1);
    check_lit("post_clr", 9'h080, 1, 1'b0, 1);

    // Reset while a result is on offer.
    ready_pct = 0;
    op_d[0] = 1;
    send_op(1, -1, 1'b1);
    check_lit("pre_rst", 9'h080, 1, 1'b0, 1);
    @(posedge clk);
    #1 i_rstn = 1'b0;
    #1 chk("rst_mid_valid", {31'd0, o_res_valid}, 32'd0);
    @(posedge clk);
    #1 i_rstn = 1'b1;
    ready_pct = 100;

    // Randomized operands with bubbles, sporadic clears and a variable consumer.
    bubble_pct = 20;
    for (int t = 0; t < 60; t++) begin
      ready_pct = $urandom_range(20, 100);
      n = $urandom_range(1, 11);
      pidx = ($urandom_range(0, 99) < 60) ? $urandom_range(0, 11) : -1;
      for (int i = 0; i < n; i++) op_d[i] = $urandom_range(0, 2) - 1;
      if ($urandom_range(0, 99) < 8) begin
        send_op(n, pidx, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      end else begin
        send_op(n, pidx, 1'b1);
      end
    end
    ready_pct = 100;
    bubble_pct = 0;
    repeat (10) drive_idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/msdf_otf_converter.md
Name: msdf_otf_converter

Overview:
- Downstream consumer of the radix-2 MSDF adder's serial output stream.
- Converts the most-significant-digit-first signed-digit stream into a left-aligned two's-complement word, using on-the-fly conversion with Q/QM registers.
- Ends the MSDF datapath where results are handed to a parallel (binary) consumer.
- Applies back-pressure on the serial bus while a converted result is awaiting pickup.

Parameters:
ACCURATE_MAX, 8'd64, maximum digits per operand; result fraction width
CNT_WIDTH, $clog2(ACCURATE_MAX+1), width of digit counter and point position

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_mbus_wen  in  1  stream write enable
i_mbus_wdata  in  2  signed digit {plus,minus}; 10=+1, 01=-1, 00/11=0
i_mbus_wpoint  in  1  digit carries binary-point marker
i_mbus_wvalid  in  1  digit valid
i_mbus_wlast  in  1  final digit of operand
o_mbus_wstop  out  1  back-pressure to upstream
o_mbus_wclr  out  1  clear request forwarded upstream
i_clr  in  1  synchronous clear from consumer
o_res_data  out  ACCURATE_MAX+1  signed result = value*2^ACCURATE_MAX
o_res_point  out  CNT_WIDTH  index of first digit with wpoint set
o_res_ndig  out  CNT_WIDTH  digits consumed (saturates at ACCURATE_MAX)
o_res_trunc  out  1  operand had more than ACCURATE_MAX digits
o_res_valid  out  1  result valid
i_res_ready  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rstn.
- Reset values:
  - state = ACC; Q = 0; QM = all ones (-1); cnt = 0.
  - All outputs 0, except o_res_point = 0.
- Digit accept: accept = state==ACC & i_mbus_wen & i_mbus_wvalid. o_mbus_wstop = (state != ACC), combinational.
- OTF update on accept, while cnt < ACCURATE_MAX (Q, QM are ACCURATE_MAX+1 bits, signed):
  - d=+1: Q <= {Q,1}; QM <= {Q,0}.
  - d=0: Q <= {Q,0}; QM <= {QM,1}.
  - d=-1: Q <= {QM,1}; QM <= {QM,0}.
  - cnt increments on each such accept.
- Overflow digits: when cnt == ACCURATE_MAX, further accepted digits are discarded and trunc_flag is set. wlast is still honoured.
- Point capture: on the first accepted digit with wpoint=1 in an operand, point_reg <= cnt (pre-increment value). If no digit is marked, point_reg = final cnt.
- States:
  - ACC: on accept with wlast=1 (after applying that digit) -> ALIGN.
  - ALIGN (1 cycle): o_res_data <= Q << (ACCURATE_MAX - cnt), where Q and cnt are the post-last-digit values. Load o_res_ndig, o_res_point, o_res_trunc; o_res_valid <= 1; -> HOLD.
  - HOLD: outputs stable while o_res_valid=1. When i_res_ready=1: o_res_valid <= 0, Q/QM/cnt/flags reinit, -> ACC. Next operand's first digit can be accepted on the following cycle.
- Latency: the edge sampling the last digit moves to ALIGN; o_res_valid is high after the next edge (2 edges total).
- i_clr:
  - Synchronous, highest priority after reset. Forces the reset state next edge, dropping any partial or pending result.
  - o_mbus_wclr is i_clr registered one cycle, reset 0.
- Alias case: wlast in the same beat as the first digit is a 1-digit operand. A wlast beat with wvalid=0 is ignored.
- i_res_ready outside HOLD is ignored.
- Reset asserted mid-operand or mid-HOLD: immediate return to reset values; no result emitted.
- Value range: |value| < 1, so no result overflow. Codes 00 and 11 are both treated as zero.

Test Plan:
- ACCURATE_MAX=8; digits +1,0,-1 (wlast on 3rd), i_res_ready=1 -> o_res_data=9'h060 (96), o_res_ndig=3, trunc=0, valid for 1 cycle 2 edges after last.
- Digits -1,+1 -> o_res_data=9'h1C0 (-64); 8 digits +1 -> 9'h0FF; 8 digits -1 -> 9'h101 (-255).
- 10 digits of +1 with wlast on 10th -> o_res_data=9'h0FF, o_res_ndig=8, o_res_trunc=1.
- Hold i_res_ready=0 for 5 cycles -> o_mbus_wstop=1 and result stable throughout, with upstream digits not consumed. Raising ready -> valid drops and wstop drops next cycle; back-to-back second operand converts correctly.
- wpoint set on 3rd digit -> o_res_point=2; no wpoint across 4 digits -> o_res_point=4.
- i_clr pulse after 2 digits -> o_mbus_wclr high 1 cycle later, no o_res_valid. Fresh operand +1 -> 9'h080. i_rstn pulse mid-HOLD -> valid=0 immediately.
